// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the iterative divider.
//   div_state_t      - controller states
//   MAX_WIDTH        - widest operand abs_w can condition
//   LEGAL_STEP_MASK  - bit s set when s quotient bits per cycle is supported
//   stepIsLegal()    - elaboration-time check of STEP against the mask
//   abs_w()          - two's-complement magnitude of a width-bit value, mod 2^width
package div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      ZERO,
      DONE
   } div_state_t;

   localparam int unsigned MAX_WIDTH = 64;

   // Supported STEP values are 1, 2 and 4.
   localparam logic [7:0] LEGAL_STEP_MASK = 8'b0001_0110;

   function automatic bit stepIsLegal(input int unsigned step);
      logic [2:0] idx;
      idx = step[2:0];
      return (step < 8) && (LEGAL_STEP_MASK[idx] == 1'b1);
   endfunction

   // The most-negative value negates to itself modulo 2^width, so it comes
   // back as the unsigned magnitude 2^(width-1).
   function automatic logic [MAX_WIDTH-1:0] abs_w(input logic [MAX_WIDTH-1:0] value,
                                                  input int unsigned width);
      logic [MAX_WIDTH-1:0] mask;
      logic [5:0]           signIdx;
      mask    = (width >= MAX_WIDTH) ? '1 : ((64'd1 << width) - 64'd1);
      signIdx = 6'(width - 1);
      if (value[signIdx])
         return (~value + 64'd1) & mask;
      return value & mask;
   endfunction

endpackage

// File: rtl/div_step.sv
// div_step: combinational STEP-bit restoring division stage.
//   remIn        - partial remainder entering the stage (always < divisor)
//   dividendIn   - dividend shift register; MSB is the next bit brought down
//   divisor      - divisor magnitude
//   remOut       - partial remainder after STEP shift/subtract steps
//   dividendOut  - dividend register shifted left by STEP, zeros shifted in
//   quotientBits - the STEP quotient bits produced, MSB first
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input  logic [WIDTH-1:0] remIn,
   input  logic [WIDTH-1:0] dividendIn,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] remOut,
   output logic [WIDTH-1:0] dividendOut,
   output logic [STEP-1:0]  quotientBits
);

   for (genvar gi = 0; gi < STEP; gi++) begin : g_stage
      logic [WIDTH-1:0] remSrc;
      logic [WIDTH-1:0] dvdSrc;
      logic [WIDTH:0]   shifted;
      logic [WIDTH:0]   trial;
      logic [WIDTH-1:0] remRes;
      logic [WIDTH-1:0] dvdRes;
      logic             fits;

      if (gi == 0) begin : g_head
         assign remSrc = remIn;
         assign dvdSrc = dividendIn;
      end else begin : g_link
         assign remSrc = g_stage[gi-1].remRes;
         assign dvdSrc = g_stage[gi-1].dvdRes;
      end

      // The stored remainder is below the divisor, so the shifted value is
      // below 2*divisor and fits in WIDTH+1 bits; a borrow out of the trial
      // subtraction therefore shows up as trial[WIDTH].
      assign shifted = {remSrc, dvdSrc[WIDTH-1]};
      assign trial   = shifted - {1'b0, divisor};
      assign fits    = ~trial[WIDTH];
      assign remRes  = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      assign dvdRes  = {dvdSrc[WIDTH-2:0], 1'b0};

      assign quotientBits[STEP-1-gi] = fits;
   end

   assign remOut      = g_stage[STEP-1].remRes;
   assign dividendOut = g_stage[STEP-1].dvdRes;

endmodule

// File: rtl/iter_divider.sv
// iter_divider: multi-cycle DIV/DIVU unit for the execute stage.
//   clk, rst          - clock, asynchronous active-high reset
//   start_i           - request a divide (honoured only in IDLE)
//   signed_i          - 1 = signed DIV, 0 = DIVU; captured with start_i
//   annul_i           - pipeline flush; cancels whatever is in progress
//   a_i, b_i          - dividend and divisor; captured with start_i
//   stall_o           - hold the pipeline front end while a divide is pending
//   ready_o           - one-cycle pulse when quotient_o/remainder_o are new
//   quotient_o        - quotient, to LO
//   remainder_o       - remainder, to HI
module iter_divider
   import div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic             annul_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             stall_o,
   output logic             ready_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o
);

   localparam int ITERS = WIDTH / STEP;
   localparam int CW    = $clog2(ITERS + 1);

   if (!((WIDTH % STEP == 0) && stepIsLegal(STEP) && (WIDTH <= MAX_WIDTH) && (WIDTH > STEP)))
   begin : g_bad_params
      $error("iter_divider: WIDTH must be a multiple of STEP and STEP one of 1, 2, 4");
   end

   div_state_t       stateReg, stateNext;
   logic [CW-1:0]    countReg;
   logic [WIDTH-1:0] remReg, dvdReg, divisorReg;
   logic             negQuotReg, negRemReg;
   logic [WIDTH-1:0] quotReg, remOutReg;

   logic             accept;
   logic             lastIter;
   logic [WIDTH-1:0] aMag, bMag;
   logic [WIDTH-1:0] stepRem, stepDvd, dvdNext;
   logic [STEP-1:0]  stepBits;

   assign accept   = (stateReg == IDLE) & start_i & ~annul_i;
   assign lastIter = (countReg == CW'(1));

   assign aMag = signed_i ? WIDTH'(abs_w(MAX_WIDTH'(a_i), WIDTH)) : a_i;
   assign bMag = signed_i ? WIDTH'(abs_w(MAX_WIDTH'(b_i), WIDTH)) : b_i;

   div_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_step (
      .remIn        (remReg),
      .dividendIn   (dvdReg),
      .divisor      (divisorReg),
      .remOut       (stepRem),
      .dividendOut  (stepDvd),
      .quotientBits (stepBits)
   );

   // Quotient bits fill the vacated low end of the dividend register, so
   // after the final iteration that register holds the whole quotient.
   assign dvdNext = stepDvd | WIDTH'(stepBits);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stateReg <= IDLE;
      else
         stateReg <= stateNext;
   end

   always_comb begin
      stateNext = stateReg;
      stall_o   = 1'b0;
      case (stateReg)
         IDLE: begin
            stall_o = start_i;
            if (accept)
               stateNext = (b_i == '0) ? ZERO : BUSY;
         end
         BUSY: begin
            stall_o = 1'b1;
            if (lastIter)
               stateNext = DONE;
         end
         ZERO: begin
            stall_o   = 1'b1;
            stateNext = DONE;
         end
         DONE: stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
      // A flush releases the pipeline in the same cycle it is raised.
      if (annul_i) begin
         stateNext = IDLE;
         stall_o   = 1'b0;
      end
      if (rst)
         stall_o = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         countReg   <= '0;
         remReg     <= '0;
         dvdReg     <= '0;
         divisorReg <= '0;
         negQuotReg <= 1'b0;
         negRemReg  <= 1'b0;
         quotReg    <= '0;
         remOutReg  <= '0;
      end else begin
         case (stateReg)
            IDLE: begin
               if (accept) begin
                  remReg     <= '0;
                  dvdReg     <= aMag;
                  divisorReg <= bMag;
                  negQuotReg <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                  negRemReg  <= signed_i & a_i[WIDTH-1];
                  countReg   <= CW'(ITERS);
               end
            end
            BUSY: begin
               remReg   <= stepRem;
               dvdReg   <= dvdNext;
               countReg <= countReg - CW'(1);
               // Sign correction is folded into the DONE-entry register write;
               // most-negative / -1 wraps naturally to the most-negative quotient.
               if (lastIter && !annul_i) begin
                  quotReg   <= negQuotReg ? -dvdNext : dvdNext;
                  remOutReg <= negRemReg ? -stepRem : stepRem;
               end
            end
            ZERO: begin
               if (!annul_i) begin
                  quotReg   <= '0;
                  remOutReg <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign ready_o     = (stateReg == DONE);
   assign quotient_o  = quotReg;
   assign remainder_o = remOutReg;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed cases plus randomized
// operands, checked against plain integer arithmetic.
module tb_iter_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start0 = 1'b0;
   logic        start4 = 1'b0;
   logic        sgnI = 1'b0;
   logic        annul = 1'b0;
   logic [31:0] aI = '0;
   logic [31:0] bI = '0;

   logic        stall0, ready0, stall4, ready4;
   logic [31:0] q0, r0, q4, r4;

   logic        sel = 1'b0;
   logic        curStall, curReady;
   logic [31:0] curQ, curR;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   iter_divider #(.WIDTH(32), .STEP(1)) dut (
      .clk(clk), .rst(rst), .start_i(start0), .signed_i(sgnI), .annul_i(annul),
      .a_i(aI), .b_i(bI), .stall_o(stall0), .ready_o(ready0),
      .quotient_o(q0), .remainder_o(r0)
   );

   iter_divider #(.WIDTH(32), .STEP(4)) dut4 (
      .clk(clk), .rst(rst), .start_i(start4), .signed_i(sgnI), .annul_i(annul),
      .a_i(aI), .b_i(bI), .stall_o(stall4), .ready_o(ready4),
      .quotient_o(q4), .remainder_o(r4)
   );

   always_comb begin
      curStall = sel ? stall4 : stall0;
      curReady = sel ? ready4 : ready0;
      curQ     = sel ? q4 : q0;
      curR     = sel ? r4 : r0;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: DIVU is plain unsigned division; DIV truncates toward zero
   // with the remainder taking the dividend's sign, computed in 64 bits so
   // that -2^31 / -1 simply wraps when cut back to 32 bits.
   function automatic void refModel(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
      longint sa, sb;
      if (b == 32'd0) begin
         q = '0;
         r = '0;
      end else if (!sgn) begin
         q = a / b;
         r = a % b;
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request in the current (IDLE) cycle and follow it to ready.
   task automatic runDiv(input bit wide, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input string name);
      logic [31:0] eq, er;
      int  n, expLat, cyc;
      bit  got, stallOk;
      n      = wide ? 8 : 32;
      expLat = (b == 32'd0) ? 2 : n + 1;
      refModel(sgn, a, b, eq, er);
      sel  = wide;
      sgnI = sgn;
      aI   = a;
      bI   = b;
      if (wide) start4 = 1'b1;
      else      start0 = 1'b1;
      #1;
      check({name, " stall_at_request"}, 64'(curStall), 64'd1);
      got = 1'b0;
      stallOk = 1'b1;
      cyc = 0;
      while (!got && cyc < 100) begin
         tick();
         start0 = 1'b0;
         start4 = 1'b0;
         aI   = $urandom;
         bI   = $urandom;
         sgnI = 1'($urandom_range(0, 1));
         #1;
         cyc++;
         if (curReady) got = 1'b1;
         else if (!curStall) stallOk = 1'b0;
      end
      check({name, " ready_cycle"}, 64'(cyc), 64'(expLat));
      check({name, " stall_while_busy"}, 64'(stallOk), 64'd1);
      check({name, " stall_at_ready"}, 64'(curStall), 64'd0);
      check({name, " quotient"}, 64'(curQ), 64'(eq));
      check({name, " remainder"}, 64'(curR), 64'(er));
      $display("txn %s step=%0d signed=%0d a=%h b=%h q=%h r=%h ready_cycle=%0d",
               name, wide ? 4 : 1, sgn, a, b, curQ, curR, cyc);
      tick();
      #1;
      check({name, " ready_single_pulse"}, 64'(curReady), 64'd0);
      check({name, " quotient_hold"}, 64'(curQ), 64'(eq));
   endtask

   initial begin
      logic [31:0] ra, rb;
      bit          rs;

      // Reset state on both instances.
      #1;
      check("reset stall0", 64'(stall0), 64'd0);
      check("reset ready0", 64'(ready0), 64'd0);
      check("reset q0", 64'(q0), 64'd0);
      check("reset r0", 64'(r0), 64'd0);
      check("reset stall4", 64'(stall4), 64'd0);
      check("reset q4", 64'(q4), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Directed cases on the one-bit-per-cycle instance.
      runDiv(1'b0, 1'b0, 32'd100, 32'd7, "divu_100_7");
      runDiv(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
      runDiv(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
      runDiv(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
      runDiv(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, "divu_full");
      runDiv(1'b0, 1'b0, 32'd5, 32'd0, "divu_by_zero");
      runDiv(1'b0, 1'b1, 32'hFFFF_FFF0, 32'd0, "div_by_zero");

      // Annul mid-operation after a 3/1 result.
      runDiv(1'b0, 1'b0, 32'd10, 32'd3, "pre_annul");
      sel    = 1'b0;
      sgnI   = 1'b0;
      aI     = 32'd100;
      bI     = 32'd7;
      start0 = 1'b1;
      #1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         start0 = 1'b0;
         #1;
      end
      check("annul stall_before", 64'(stall0), 64'd1);
      tick();
      annul = 1'b1;
      #1;
      check("annul stall_same_cycle", 64'(stall0), 64'd0);
      check("annul no_ready_c10", 64'(ready0), 64'd0);
      tick();
      annul = 1'b0;
      #1;
      check("annul idle_c11", 64'(stall0), 64'd0);
      check("annul no_ready_c11", 64'(ready0), 64'd0);
      check("annul q_kept", 64'(q0), 64'd3);
      check("annul r_kept", 64'(r0), 64'd1);
      tick();
      runDiv(1'b0, 1'b0, 32'd100, 32'd7, "after_annul");

      // Four bits per cycle.
      runDiv(1'b1, 1'b0, 32'd1000, 32'd3, "step4_1000_3");
      runDiv(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "step4_overflow");
      runDiv(1'b1, 1'b0, 32'd9, 32'd0, "step4_by_zero");
      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 28);
         rs = 1'($urandom_range(0, 1));
         runDiv(1'b1, rs, ra, rb, $sformatf("step4_rand%0d", i));
      end

      // Randomized operands with the special values mixed in.
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 15));
            2: rb = 32'hFFFF_FFFF;
            3: rb = 32'h8000_0000;
            default: rb = $urandom >> $urandom_range(0, 30);
         endcase
         ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         rs = 1'($urandom_range(0, 1));
         runDiv(1'b0, rs, ra, rb, $sformatf("rand%0d", i));
      end

      // Reset in cycle 5 of a divide, with non-zero results on both instances.
      runDiv(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, "pre_reset");
      sel    = 1'b0;
      sgnI   = 1'b0;
      aI     = 32'd1000;
      bI     = 32'd3;
      start0 = 1'b1;
      #1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         start0 = 1'b0;
         #1;
      end
      rst = 1'b1;
      #1;
      check("reset_mid q0", 64'(q0), 64'd0);
      check("reset_mid r0", 64'(r0), 64'd0);
      check("reset_mid stall0", 64'(stall0), 64'd0);
      check("reset_mid ready0", 64'(ready0), 64'd0);
      check("reset_mid q4", 64'(q4), 64'd0);
      tick();
      rst = 1'b0;
      #1;
      check("reset_release stall0", 64'(stall0), 64'd0);
      check("reset_release ready0", 64'(ready0), 64'd0);
      tick();
      runDiv(1'b0, 1'b0, 32'd1000, 32'd3, "after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iter_divider.md
# iter_divider

Parametrised multi-cycle integer divider for the execute stage of the MIPS pipeline. It replaces the fixed 32-bit, one-bit-per-cycle divider behind the `start_divE` / `signed_divE` / `div_readyE` / `stall_divE` nets. It generalises operand width and quotient bits retired per cycle, and adds exception annulment and a short divide-by-zero path. Quotient and remainder feed the LO and HI write-back path.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; must be a multiple of `STEP`.
- `STEP`, 1: quotient bits produced per cycle; legal values 1, 2, 4.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start_i`  in  1  request a divide; sampled only in IDLE.
- `signed_i`  in  1  1 = DIV (two's complement), 0 = DIVU; captured with `start_i`.
- `annul_i`  in  1  flush from exception/eret; cancels any operation.
- `a_i`  in  `WIDTH`  dividend; captured with `start_i`.
- `b_i`  in  `WIDTH`  divisor; captured with `start_i`.
- `stall_o`  out  1  hold the pipeline front end; reset 0.
- `ready_o`  out  1  one-cycle pulse, results valid; reset 0.
- `quotient_o`  out  `WIDTH`  to LO; reset 0.
- `remainder_o`  out  `WIDTH`  to HI; reset 0.

## Operation
- FSM states: IDLE, BUSY, ZERO, DONE. Reset state is IDLE.
- **Accepting a request.** In IDLE, `start_i & ~annul_i` latches operands and `signed_i`.
  - Next state is ZERO if `b_i == 0`.
  - Otherwise next state is BUSY, with the iteration counter loaded to N = `WIDTH/STEP`.
- **Operand conditioning.** When `signed_i` is 1, magnitudes are taken first. Negation of the most-negative value is done modulo 2^`WIDTH`, so 0x80000000 is treated as unsigned 2^31.
- **BUSY.** Each cycle runs `STEP` restoring shift/subtract steps on a `WIDTH+1`-bit partial remainder and decrements the counter. When the counter reaches 1, the next edge goes to DONE.
- **Entering DONE (registered sign correction).**
  - Quotient is negated if the operand signs differed.
  - Remainder takes the sign of the dividend.
  - Most-negative / −1 yields quotient 0x80000000, remainder 0 (wrap, no trap).
- **ZERO.** Lasts one cycle, then goes to DONE with quotient 0 and remainder 0.
- **DONE.**
  - `ready_o` = 1 and `quotient_o` / `remainder_o` hold the new result.
  - The next edge always goes to IDLE; `start_i` is ignored in DONE.
  - Results hold unchanged until the next DONE.
- **Stall.** `stall_o` = (IDLE & `start_i` & ~`annul_i`) | BUSY | ZERO. It is combinational, so the pipeline stalls in the same cycle as the request, and it is low in DONE.
- **Annulment.**
  - `annul_i` in any state forces IDLE at the next edge; `stall_o` drops in the same cycle.
  - No `ready_o` is produced, and result registers keep their previous values.
  - `annul_i` has priority over `start_i`.
- **Reset.** `rst` asserted mid-operation forces IDLE immediately and zeroes all outputs. `stall_o` is gated low while `rst` is high.
- **Controller contract.** `start_i` must be deasserted in the cycle following `ready_o`, otherwise a second divide starts.

## Timing
- Start sampled at the end of cycle 0.
  - Normal divide: BUSY in cycles 1..N, `ready_o` in cycle N+1. Default parameters give cycle 33; `STEP`=4 gives cycle 9.
  - Divide by zero: ZERO in cycle 1, `ready_o` in cycle 2.
- `stall_o` is high in cycles 0..N (0..1 for divide by zero) and low from the `ready_o` cycle.
- Back-to-back: the earliest next start is sampled in the cycle after `ready_o` (IDLE).
- Annul asserted in cycle k: `stall_o` is low in cycle k, and the state is IDLE in cycle k+1.

## Structure
- Package `div_pkg`:
  - state enum `div_state_t` {IDLE, BUSY, ZERO, DONE};
  - function `abs_w` (two's-complement magnitude, modulo 2^`WIDTH`);
  - legal-`STEP` check constant.
- Sub-module `div_step`: combinational `STEP`-bit restoring stage.
  - Inputs: partial remainder, dividend shift register, divisor.
  - Outputs: next remainder and quotient bits.
  - Instantiated once in `iter_divider`.
- Elaboration-time assertion: `WIDTH % STEP == 0` and `STEP` in {1, 2, 4}.

## Test plan
- **Unsigned default.** DIVU 100 / 7 → `ready_o` in cycle 33, quotient 14, remainder 2; `stall_o` high in cycles 0..32.
- **Signed with negative dividend.** DIV −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Check DIV 7 / −2 → quotient 0xFFFFFFFD, remainder 1.
- **Overflow and unsigned full range.** DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. DIVU 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- **Divide by zero.** DIVU 5 / 0 → `ready_o` in cycle 2, quotient 0, remainder 0.
- **Annul mid-operation.** Start 100 / 7 after a prior result (q=3, r=1), then `annul_i` in cycle 10. Required: `stall_o` low in cycle 10, no `ready_o`, outputs stay 3/1. A new start in cycle 12 completes normally in cycle 45.
- **Wide step and reset.** With `STEP`=4: 1000 / 3 → `ready_o` in cycle 9, quotient 333, remainder 1. Separately, `rst` asserted in cycle 5 of a divide → outputs 0 immediately, IDLE after release.
